// File: rtl/text_pkg.sv
// Shared constants and state encoding for the text writer and its cursor tracker.
package text_pkg;

    localparam int COLS_DEFAULT = 80;
    localparam int ROWS_DEFAULT = 25;

    localparam logic [7:0] CR    = 8'h0D;
    localparam logic [7:0] LF    = 8'h0A;
    localparam logic [7:0] BS    = 8'h08;
    localparam logic [7:0] FF    = 8'h0C;
    localparam logic [7:0] SPACE = 8'h20;

    localparam logic [7:0] PRINT_LO = 8'h20;
    localparam logic [7:0] PRINT_HI = 8'h7E;

    typedef enum logic {
        IDLE,
        CLEAR
    } state_t;

endpackage

// File: rtl/text_cursor.sv
// Cursor column/row tracker that keeps the linear RAM address row*COLS+col
// up to date incrementally, without a multiplier.
module text_cursor #(
    parameter int COLS       = 80,
    parameter int ROWS       = 25,
    parameter int ADDR_WIDTH = 11
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      advance,
    input  logic                      back,
    input  logic                      newline,
    input  logic                      home,
    input  logic                      zero,
    output logic [$clog2(COLS)-1:0]   col,
    output logic [$clog2(ROWS)-1:0]   row,
    output logic [ADDR_WIDTH-1:0]     addr
);

    localparam int CW = $clog2(COLS);
    localparam int RW = $clog2(ROWS);
    localparam logic [CW-1:0] COL_LAST = CW'(COLS - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col  <= '0;
            row  <= '0;
            addr <= '0;
        end else if (zero) begin
            col  <= '0;
            row  <= '0;
            addr <= '0;
        end else if (advance) begin
            if (col == COL_LAST) begin
                col <= '0;
                if (row == ROW_LAST) begin
                    row  <= '0;
                    addr <= '0;
                end else begin
                    row  <= row + RW'(1);
                    addr <= addr + ADDR_WIDTH'(1);
                end
            end else begin
                col  <= col + CW'(1);
                addr <= addr + ADDR_WIDTH'(1);
            end
        end else if (back) begin
            if (col != '0) begin
                col  <= col - CW'(1);
                addr <= addr - ADDR_WIDTH'(1);
            end
        end else if (newline) begin
            // Wrapping to the top row leaves the address equal to the column.
            if (row == ROW_LAST) begin
                row  <= '0;
                addr <= ADDR_WIDTH'(col);
            end else begin
                row  <= row + RW'(1);
                addr <= addr + ADDR_WIDTH'(COLS);
            end
        end else if (home) begin
            col  <= '0;
            addr <= addr - ADDR_WIDTH'(col);
        end
    end

endmodule

// File: rtl/text_writer.sv
// Byte-stream text writer: printable bytes go to character RAM, control codes move the cursor.
// Optional macro TEXT_WRITER_CLEAR_ON_RESET_EN clears the screen after every reset.
module text_writer
    import text_pkg::*;
#(
    parameter int COLS       = COLS_DEFAULT,
    parameter int ROWS       = ROWS_DEFAULT,
    parameter int ADDR_WIDTH = 11,
    parameter int DATA_WIDTH = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [DATA_WIDTH-1:0]     in_data,
    input  logic                      in_valid,
    output logic                      in_ready,
    output logic                      ram_we,
    output logic [ADDR_WIDTH-1:0]     ram_waddr,
    output logic [DATA_WIDTH-1:0]     ram_din,
    output logic [$clog2(COLS)-1:0]   cursor_col,
    output logic [$clog2(ROWS)-1:0]   cursor_row,
    output logic                      busy
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(COLS * ROWS - 1);

`ifdef TEXT_WRITER_CLEAR_ON_RESET_EN
    localparam logic CLEAR_AT_START = 1'b1;
`else
    localparam logic CLEAR_AT_START = 1'b0;
`endif

    state_t                  state;
    logic                    pending_clear;
    logic                    accept;
    logic                    is_print;
    logic                    is_cr;
    logic                    is_lf;
    logic                    is_bs;
    logic                    is_ff;
    logic                    sweep_done;
    logic [ADDR_WIDTH-1:0]   cur_addr;

    assign in_ready   = (state == IDLE) && !pending_clear;
    assign busy       = (state == CLEAR);
    assign accept     = in_valid && in_ready;
    assign is_print   = (in_data >= DATA_WIDTH'(PRINT_LO)) && (in_data <= DATA_WIDTH'(PRINT_HI));
    assign is_cr      = (in_data == DATA_WIDTH'(CR));
    assign is_lf      = (in_data == DATA_WIDTH'(LF));
    assign is_bs      = (in_data == DATA_WIDTH'(BS));
    assign is_ff      = (in_data == DATA_WIDTH'(FF));
    assign sweep_done = (state == CLEAR) && (ram_waddr == LAST_ADDR);

    text_cursor #(
        .COLS       (COLS),
        .ROWS       (ROWS),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_cursor (
        .clk     (clk),
        .rst     (rst),
        .advance (accept && is_print),
        .back    (accept && is_bs),
        .newline (accept && is_lf),
        .home    (accept && is_cr),
        .zero    (sweep_done),
        .col     (cursor_col),
        .row     (cursor_row),
        .addr    (cur_addr)
    );

    // During CLEAR the write address register doubles as the sweep counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            pending_clear <= CLEAR_AT_START;
            ram_we        <= 1'b0;
            ram_waddr     <= '0;
            ram_din       <= '0;
        end else if (pending_clear) begin
            pending_clear <= 1'b0;
            state         <= CLEAR;
            ram_we        <= 1'b1;
            ram_waddr     <= '0;
            ram_din       <= DATA_WIDTH'(SPACE);
        end else begin
            case (state)
                IDLE: begin
                    ram_we <= 1'b0;
                    if (accept) begin
                        if (is_print) begin
                            ram_we    <= 1'b1;
                            ram_waddr <= cur_addr;
                            ram_din   <= in_data;
                        end else if (is_bs && (cursor_col != '0)) begin
                            ram_we    <= 1'b1;
                            ram_waddr <= cur_addr - ADDR_WIDTH'(1);
                            ram_din   <= DATA_WIDTH'(SPACE);
                        end else if (is_ff) begin
                            state     <= CLEAR;
                            ram_we    <= 1'b1;
                            ram_waddr <= '0;
                            ram_din   <= DATA_WIDTH'(SPACE);
                        end
                    end
                end
                CLEAR: begin
                    if (ram_waddr == LAST_ADDR) begin
                        state  <= IDLE;
                        ram_we <= 1'b0;
                    end else begin
                        ram_waddr <= ram_waddr + ADDR_WIDTH'(1);
                    end
                end
                default: begin
                    state  <= IDLE;
                    ram_we <= 1'b0;
                end
            endcase
        end
    end

endmodule
